// File: rtl/clock_core_param.sv
// clock_core_param: BCD hh:mm:ss timekeeper with a CLK_HZ prescaler, manual set under hold
// and optional 12-hour display. Define CLOCK_CORE_ALARM_EN to add the hh:mm alarm.
module clock_core_param #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned HOUR_12 = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_hold,
  input  logic [1:0] i_sel,
  input  logic       i_inc,
`ifdef CLOCK_CORE_ALARM_EN
  input  logic       i_alm_en,
  input  logic [7:0] i_alm_hr_bcd,
  input  logic [7:0] i_alm_min_bcd,
  output logic       o_alarm,
`endif
  output logic [7:0] o_sec_bcd,
  output logic [7:0] o_min_bcd,
  output logic [7:0] o_hr_bcd,
  output logic       o_pm,
  output logic       o_tick
);

  localparam int unsigned   PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [7:0]    HR_RST  = (HOUR_12 != 0) ? 8'h12 : 8'h00;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_c, tick_q;
  logic [7:0]    sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic [7:0]    hr_disp_q, hr_disp_d;
  logic          pm_q, pm_d;
  logic [8:0]    sec_inc, min_inc;
  logic [7:0]    hr_inc;

  // {wrap, next} for a 00..59 BCD field
  function automatic logic [8:0] inc_mod60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return {1'b1, 8'h00};
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    end
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_mod24(input logic [7:0] v);
    if (v == 8'h23)     return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // {pm, display hour} straight from the BCD hour, avoiding a binary round trip
  function automatic logic [8:0] to_12h(input logic [7:0] h);
    logic [8:0] r;
    case (h)
      8'h00:   r = {1'b0, 8'h12};
      8'h12:   r = {1'b1, 8'h12};
      8'h20:   r = {1'b1, 8'h08};
      8'h21:   r = {1'b1, 8'h09};
      8'h22:   r = {1'b1, 8'h10};
      8'h23:   r = {1'b1, 8'h11};
      default: r = (h > 8'h12) ? {1'b1, h - 8'h12} : {1'b0, h};
    endcase
    return r;
  endfunction

  assign sec_inc = inc_mod60(sec_q);
  assign min_inc = inc_mod60(min_q);
  assign hr_inc  = inc_mod24(hr_q);

  always_comb begin
    presc_d = presc_q;
    tick_c  = 1'b0;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    if (i_hold) begin
      presc_d = '0;
      if (i_inc) begin
        case (i_sel)
          2'b01:   sec_d = sec_inc[7:0];
          2'b10:   min_d = min_inc[7:0];
          2'b11:   hr_d  = hr_inc;
          default: ;
        endcase
      end
    end else if (presc_q == PRE_MAX) begin
      presc_d = '0;
      tick_c  = 1'b1;
      sec_d   = sec_inc[7:0];
      if (sec_inc[8]) begin
        min_d = min_inc[7:0];
        if (min_inc[8]) hr_d = hr_inc;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Display hour is registered from the next-state hour so it moves with the counters
  always_comb begin
    pm_d      = 1'b0;
    hr_disp_d = hr_d;
    if (HOUR_12 != 0) {pm_d, hr_disp_d} = to_12h(hr_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      hr_disp_q <= HR_RST;
      pm_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_c;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      hr_disp_q <= hr_disp_d;
      pm_q      <= pm_d;
    end
  end

  assign o_sec_bcd = sec_q;
  assign o_min_bcd = min_q;
  assign o_hr_bcd  = hr_disp_q;
  assign o_pm      = pm_q;
  assign o_tick    = tick_q;

`ifdef CLOCK_CORE_ALARM_EN
  logic alarm_q, alarm_d;

  // Compare against next-state time so the alarm rises with the minute it matches
  assign alarm_d = i_alm_en && !i_hold && (hr_d == i_alm_hr_bcd) && (min_d == i_alm_min_bcd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) alarm_q <= 1'b0;
    else          alarm_q <= alarm_d;
  end

  assign o_alarm = alarm_q;
`endif

endmodule

// File: tb/tb_clock_core_param.sv
// Scoreboard bench for clock_core_param: an integer time model pushes expected outputs
// each cycle; 24-hour and 12-hour instances are compared after every clock edge.
module tb_clock_core_param;
  localparam int CLK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       hold = 1'b0;
  logic       inc = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       alm_en = 1'b0;
  int         alm_h = 0, alm_m = 0;

  logic [7:0] a_sec, a_min, a_hr, b_sec, b_min, b_hr;
  logic       a_pm, a_tick, b_pm, b_tick;
`ifdef CLOCK_CORE_ALARM_EN
  logic       a_alarm, b_alarm;
  logic [7:0] alm_hr_bcd, alm_min_bcd;
  assign alm_hr_bcd  = bcd(alm_h);
  assign alm_min_bcd = bcd(alm_m);
`endif

  clock_core_param #(.CLK_HZ(CLK), .HOUR_12(0)) dut24 (
    .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_sel(sel), .i_inc(inc),
`ifdef CLOCK_CORE_ALARM_EN
    .i_alm_en(alm_en), .i_alm_hr_bcd(alm_hr_bcd), .i_alm_min_bcd(alm_min_bcd), .o_alarm(a_alarm),
`endif
    .o_sec_bcd(a_sec), .o_min_bcd(a_min), .o_hr_bcd(a_hr), .o_pm(a_pm), .o_tick(a_tick)
  );

  clock_core_param #(.CLK_HZ(CLK), .HOUR_12(1)) dut12 (
    .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_sel(sel), .i_inc(inc),
`ifdef CLOCK_CORE_ALARM_EN
    .i_alm_en(alm_en), .i_alm_hr_bcd(alm_hr_bcd), .i_alm_min_bcd(alm_min_bcd), .o_alarm(b_alarm),
`endif
    .o_sec_bcd(b_sec), .o_min_bcd(b_min), .o_hr_bcd(b_hr), .o_pm(b_pm), .o_tick(b_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sec, min, hr24, hr12;
    logic       pm, tick, alarm;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   m_presc = 0, m_sec = 0, m_min = 0, m_hr = 0;
  logic m_tick = 1'b0, m_alarm = 1'b0;

  function automatic logic [7:0] bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_advance();
    if (hold) begin
      m_presc = 0;
      m_tick  = 1'b0;
      if (inc) begin
        case (sel)
          2'd1:    m_sec = (m_sec + 1) % 60;
          2'd2:    m_min = (m_min + 1) % 60;
          2'd3:    m_hr  = (m_hr + 1) % 24;
          default: ;
        endcase
      end
    end else if (m_presc == CLK - 1) begin
      m_presc = 0;
      m_tick  = 1'b1;
      m_sec++;
      if (m_sec == 60) begin
        m_sec = 0;
        m_min++;
        if (m_min == 60) begin
          m_min = 0;
          m_hr  = (m_hr + 1) % 24;
        end
      end
    end else begin
      m_presc++;
      m_tick = 1'b0;
    end
    m_alarm = alm_en && !hold && (m_hr == alm_h) && (m_min == alm_m);
  endtask

  task automatic push_expected();
    exp_t e;
    e.sec   = bcd(m_sec);
    e.min   = bcd(m_min);
    e.hr24  = bcd(m_hr);
    e.hr12  = bcd((m_hr % 12 == 0) ? 12 : m_hr % 12);
    e.pm    = (m_hr >= 12);
    e.tick  = m_tick;
    e.alarm = m_alarm;
    exp_q.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    e = exp_q.pop_front();
    check("sec24", a_sec, e.sec);
    check("sec12", b_sec, e.sec);
    check("min24", a_min, e.min);
    check("min12", b_min, e.min);
    check("hr24", a_hr, e.hr24);
    check("hr12", b_hr, e.hr12);
    check("pm24", a_pm, 0);
    check("pm12", b_pm, e.pm);
    check("tick24", a_tick, e.tick);
    check("tick12", b_tick, e.tick);
`ifdef CLOCK_CORE_ALARM_EN
    check("alarm24", a_alarm, e.alarm);
    check("alarm12", b_alarm, e.alarm);
`endif
  endtask

  task automatic step();
    model_advance();
    push_expected();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic reset_dut();
    rst_n   = 1'b0;
    m_presc = 0; m_sec = 0; m_min = 0; m_hr = 0;
    m_tick  = 1'b0; m_alarm = 1'b0;
    #1;
    push_expected();
    compare_outputs();
    check("rst_hr24_const", a_hr, 8'h00);
    check("rst_hr12_const", b_hr, 8'h12);
    check("rst_pm12_const", b_pm, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [1:0] f);
    sel = f;
    inc = 1'b1;
    step();
    inc = 1'b0;
    step();
  endtask

  function automatic int mfield(input logic [1:0] f);
    case (f)
      2'd1:    return m_sec;
      2'd2:    return m_min;
      default: return m_hr;
    endcase
  endfunction

  task automatic set_field(input logic [1:0] f, input int target);
    for (int g = 0; g < 70 && mfield(f) != target; g++) pulse(f);
  endtask

  initial begin
    int saved, cnt;
    #2;
    reset_dut();

    // free-running ticks from reset release
    for (int i = 1; i <= 16; i++) begin
      step();
      check("tick_pattern", a_tick, (i % 4 == 0) ? 1 : 0);
    end
    check("sec_after16", a_sec, 8'h04);

    // 12-hour mapping and preload of 23:59:59
    hold = 1'b1;
    step();
    check("h00_disp", b_hr, 8'h12);
    check("h00_pm", b_pm, 0);
    set_field(2'd3, 12);
    check("h12_disp", b_hr, 8'h12);
    check("h12_pm", b_pm, 1);
    set_field(2'd3, 13);
    check("h13_disp", b_hr, 8'h01);
    check("h13_pm", b_pm, 1);
    set_field(2'd3, 23);
    set_field(2'd2, 59);
    set_field(2'd1, 59);
    hold = 1'b0;
    sel  = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("pre_roll_sec", a_sec, 8'h59);
      check("pre_roll_hr", a_hr, 8'h23);
    end
    step();
    check("roll_sec", a_sec, 8'h00);
    check("roll_min", a_min, 8'h00);
    check("roll_hr", a_hr, 8'h00);
    check("roll_tick", a_tick, 1);

    // set wraps without carry; inc ignored with sel=00 or hold=0
    hold = 1'b1;
    set_field(2'd1, 59);
    saved = int'(a_min);
    pulse(2'd1);
    check("set_wrap_sec", a_sec, 8'h00);
    check("set_no_carry", a_min, saved);
    pulse(2'd0);
    check("sel0_ignored", a_sec, 8'h00);
    hold = 1'b0;
    sel  = 2'b01;
    inc  = 1'b1;
    step();
    inc  = 1'b0;
    check("run_inc_ignored", a_sec, 8'h00);

    // hold raised on the tick cycle wins
    for (int g = 0; g < 8 && m_presc != CLK - 1; g++) step();
    saved = int'(a_sec);
    hold  = 1'b1;
    step();
    check("hold_no_tick", a_tick, 0);
    check("hold_no_inc", a_sec, saved);
    hold = 1'b0;
    cnt  = 0;
    for (int g = 1; g <= 10; g++) begin
      step();
      if (a_tick) begin
        cnt = g;
        break;
      end
    end
    check("tick_after_hold", cnt, 4);

    // asynchronous reset in the middle of a set strobe
    hold = 1'b1;
    set_field(2'd2, 5);
    sel = 2'b10;
    inc = 1'b1;
    reset_dut();
    inc = 1'b0;
    step();
    check("rst_abort_min", a_min, 8'h00);
    hold = 1'b0;

`ifdef CLOCK_CORE_ALARM_EN
    hold = 1'b1;
    set_field(2'd3, 7);
    set_field(2'd2, 29);
    set_field(2'd1, 59);
    alm_h  = 7;
    alm_m  = 30;
    alm_en = 1'b1;
    hold   = 1'b0;
    sel    = 2'b00;
    cnt    = 0;
    for (int g = 1; g <= 8 && !a_tick; g++) step();
    check("alarm_rise", a_alarm, 1);
    check("alarm_rise_min", a_min, 8'h30);
    for (int g = 0; g < 400 && a_alarm; g++) begin
      cnt++;
      step();
    end
    check("alarm_cycles", cnt, 240);
    check("alarm_end_min", a_min, 8'h31);
    hold = 1'b1;
    set_field(2'd2, 30);
    hold = 1'b0;
    step();
    check("alarm_rearm", a_alarm, 1);
    alm_en = 1'b0;
    step();
    check("alarm_en_drop", a_alarm, 0);
    alm_en = 1'b1;
    step();
    check("alarm_en_back", a_alarm, 1);
    hold = 1'b1;
    step();
    check("alarm_hold_drop", a_alarm, 0);
    hold = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/clock_core_param.md
CLOCK_CORE_PARAM -- requirements
Module: clock_core_param

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning i_clk cycles per second (legal range >= 2).
REQ-002 The block SHALL have parameter HOUR_12, default 0, meaning 0 = 24-hour display and 1 = 12-hour display with AM/PM.
REQ-003 i_clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_hold  in  1  1 = timekeeping frozen and manual set enabled.
REQ-006 i_sel  in  2  field select for manual set: 00 none, 01 seconds, 10 minutes, 11 hours.
REQ-007 i_inc  in  1  single-cycle increment strobe, already debounced and pulse-shaped upstream.
REQ-008 o_sec_bcd  out  8  seconds as two BCD digits, {tens, units}.
REQ-009 o_min_bcd  out  8  minutes as two BCD digits.
REQ-010 o_hr_bcd  out  8  display hour as two BCD digits, per HOUR_12.
REQ-011 o_pm  out  1  1 = PM when HOUR_12=1; tied to 0 when HOUR_12=0.
REQ-012 o_tick  out  1  one-cycle pulse per elapsed second.

Function
REQ-013 The prescaler SHALL be $clog2(CLK_HZ) bits wide and count 0..CLK_HZ-1 while i_hold=0.
REQ-014 A tick SHALL occur on the cycle the prescaler equals CLK_HZ-1; the prescaler then wraps to 0.
REQ-015 o_tick SHALL be registered and high for exactly the one cycle after the tick cycle.
REQ-016 While i_hold=1, the prescaler SHALL be cleared to 0 and no tick SHALL occur; counting resumes from 0 on release.
REQ-017 Seconds, minutes and hours SHALL be held internally as BCD counters: sec 00..59, min 00..59, hour 00..23.
REQ-018 On a tick, seconds SHALL increment; 59 -> 00 SHALL carry into minutes, and minutes 59 -> 00 SHALL carry into hours in the same cycle.
REQ-019 Hours 23 -> 00 SHALL wrap, so 23:59:59 -> 00:00:00 occurs in a single cycle.
REQ-020 All outputs SHALL be registered and SHALL reflect the new time one cycle after the causing event.
REQ-021 When i_hold=1 and i_inc=1, the field selected by i_sel SHALL increment by 1 with wrap (59->00, 23->00) and no carry into other fields.
REQ-022 i_inc SHALL be ignored when i_hold=0 or i_sel=00.
REQ-023 When i_hold rises on a tick cycle, i_hold SHALL win: no tick and no count occur.
REQ-024 Mapping for HOUR_12=1: internal 00 -> 12 AM; 01..11 -> AM; 12 -> 12 PM; 13..23 -> (h-12) PM.
REQ-025 No BCD digit on any output SHALL ever exceed 9.

Reset
REQ-026 While i_rst_n=0, all state SHALL clear asynchronously: prescaler 0, time 00:00:00, o_tick 0, o_alarm 0.
REQ-027 Under reset, o_hr_bcd SHALL read 8'h12 with o_pm=0 when HOUR_12=1, and 8'h00 when HOUR_12=0.
REQ-028 Reset release SHALL be synchronous to i_clk; the first tick SHALL come CLK_HZ cycles after release.
REQ-029 A reset asserted mid-set or mid-carry SHALL abort the operation with no partial update retained.

Configuration
REQ-030 With macro CLOCK_CORE_ALARM_EN defined, the block SHALL add ports i_alm_en (in, 1), i_alm_hr_bcd (in, 8, 24-hour BCD), i_alm_min_bcd (in, 8) and o_alarm (out, 1).
REQ-031 With CLOCK_CORE_ALARM_EN defined, o_alarm SHALL be registered and high while i_alm_en=1, i_hold=0, the internal hour equals i_alm_hr_bcd and the minute equals i_alm_min_bcd, giving 60 s of alarm.
REQ-032 With CLOCK_CORE_ALARM_EN defined, o_alarm SHALL fall the cycle after i_alm_en falls or i_hold rises.
REQ-033 Without CLOCK_CORE_ALARM_EN, the alarm ports and logic SHALL be absent.

Verification (CLK_HZ=4)
REQ-034 Release reset, run 16 cycles -> o_tick pulses at cycles 4, 8, 12 and 16; o_sec_bcd=8'h04.
REQ-035 Preload 23:59:59 via set, release hold, wait 4 cycles -> 00:00:00, all three fields updating in the same cycle.
REQ-036 i_hold=1, i_sel=01, sec=59, pulse i_inc -> sec=00 and min unchanged; with i_hold=0, pulse i_inc -> no change.
REQ-037 HOUR_12=1: set internal hours to 00, 12 and 13 -> o_hr_bcd/o_pm read 12/0, 12/1 and 01/1 respectively.
REQ-038 Assert i_hold on the tick cycle -> no increment and o_tick stays 0; release -> the next tick comes 4 cycles later.
REQ-039 ALARM_EN build, alarm 07:30, time 07:29:59, tick -> o_alarm=1 one cycle later, stays 1 for 60 ticks, and drops immediately when i_alm_en=0.
